// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and frame width
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser (clk, rst, d -> q) with parameterised reset value
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[0], d};
  always_ff @(posedge clk) ff_q <= rst ? {2{RST_VAL}} : ff_d;
  assign q = ff_q[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: APB-gated 8N1 UART receiver (PCLK/PRESET, PSEL2&PENABLE&~PWRITE enable, rx_serial in; rx_parallel, rx_done, PREADY out)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CPB = 10
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PENABLE,
  input  logic       PSEL2,
  input  logic [7:0] PADDR,
  input  logic       PWRITE,
  input  logic       rx_serial,
  output logic       PREADY,
  output logic       rx_done,
  output logic [7:0] rx_parallel
);
  localparam int CW = $clog2(CPB);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, par_q, par_d;
  logic done_q, done_d;
  logic rx_s, en, unused_paddr;
  assign unused_paddr = ^PADDR;
  assign en = PSEL2 & PENABLE & ~PWRITE;
  sync2 #(.RST_VAL(1'b1)) u_sync (.clk(PCLK), .rst(PRESET), .d(rx_serial), .q(rx_s));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else cnt_d = cnt_q + 1'b1;
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LAST_BIT) state_d = STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? DONE : IDLE;
          par_d   = rx_s ? shift_q : par_q;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!en && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      par_d   = par_q;
    end
    done_d = state_d == DONE;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end
  assign rx_done     = done_q;
  assign PREADY      = done_q;
  assign rx_parallel = par_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard-driven checks of frame capture, errors, gating, reset and back-to-back frames
module tb_uart_receiver;
  localparam int CPB = 10;
  logic clk = 1'b0, rst = 1'b1, penable = 1'b1, psel2 = 1'b1, pwrite = 1'b0, rx = 1'b1;
  logic [7:0] paddr = 8'h00;
  logic pready, rx_done;
  logic [7:0] rx_parallel;
  int n_checks = 0, n_fail = 0, pulses = 0, cyc = 0, done_cyc = 0;
  logic prev_done = 1'b0;
  logic [7:0] exp_q[$];
  uart_receiver #(.CPB(CPB)) dut (
    .PCLK(clk), .PRESET(rst), .PENABLE(penable), .PSEL2(psel2), .PADDR(paddr),
    .PWRITE(pwrite), .rx_serial(rx), .PREADY(pready), .rx_done(rx_done), .rx_parallel(rx_parallel)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      pulses++;
      done_cyc = cyc;
      n_checks += 3;
      if (pready !== 1'b1) begin n_fail++; $display("FAIL pready_pulse: PREADY=%b required 1", pready); end
      if (prev_done === 1'b1) begin n_fail++; $display("FAIL done_width: rx_done high for more than one cycle"); end
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL unexpected_frame: got %h, none required", rx_parallel); end
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_parallel !== e) begin n_fail++; $display("FAIL frame_data: got %h required %h", rx_parallel, e); end
      end
    end else if (pready !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL pready_idle: PREADY=%b required 0", pready);
    end
    prev_done = rx_done;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = d[i]; tick(CPB); end
    rx = stop; tick(CPB);
    rx = 1'b1;
  endtask
  task automatic test_reset;
    int p0;
    rst = 1'b1; tick(3); rst = 1'b0; tick(1);
    n_checks += 3;
    if (rx_parallel !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h required 00", rx_parallel); end
    if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", rx_done); end
    if (pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b required 0", pready); end
    p0 = pulses; tick(50);
    n_checks++;
    if (pulses != p0) begin n_fail++; $display("FAIL idle_line: %0d pulses required 0", pulses - p0); end
  endtask
  task automatic test_framing_error;
    int p0 = pulses;
    send_frame(8'h6C, 1'b0); tick(30);
    n_checks += 2;
    if (pulses != p0) begin n_fail++; $display("FAIL framing_pulse: %0d pulses required 0", pulses - p0); end
    if (rx_parallel !== 8'h00) begin n_fail++; $display("FAIL framing_data: got %h required 00", rx_parallel); end
  endtask
  task automatic test_glitch;
    int p0 = pulses;
    rx = 1'b0; tick(3); rx = 1'b1; tick(30);
    n_checks += 2;
    if (pulses != p0) begin n_fail++; $display("FAIL glitch_pulse: %0d pulses required 0", pulses - p0); end
    if (rx_parallel !== 8'h00) begin n_fail++; $display("FAIL glitch_data: got %h required 00", rx_parallel); end
  endtask
  task automatic test_valid_frame;
    int p0 = pulses, t0;
    exp_q.push_back(8'h6C);
    t0 = cyc;
    send_frame(8'h6C, 1'b1); tick(20);
    n_checks += 3;
    if (pulses != p0 + 1) begin n_fail++; $display("FAIL valid_pulse: %0d pulses required 1", pulses - p0); end
    if (rx_parallel !== 8'h6C) begin n_fail++; $display("FAIL valid_data: got %h required 6c", rx_parallel); end
    if (done_cyc - t0 < 95 || done_cyc - t0 > 100) begin
      n_fail++; $display("FAIL valid_latency: got %0d cycles required 95..100", done_cyc - t0);
    end
  endtask
  task automatic test_reset_mid_frame;
    logic [7:0] d = 8'h5A;
    int p0 = pulses;
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) begin rx = d[i]; tick(CPB); end
    rx = d[4]; tick(5);
    rst = 1'b1; tick(1); rst = 1'b0;
    n_checks += 3;
    if (rx_parallel !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h required 00", rx_parallel); end
    if (rx_done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b required 0", rx_done); end
    if (pready !== 1'b0) begin n_fail++; $display("FAIL midreset_pready: got %b required 0", pready); end
    tick(5); rx = 1'b1; tick(60);
    n_checks++;
    if (pulses != p0) begin n_fail++; $display("FAIL midreset_pulse: %0d pulses required 0", pulses - p0); end
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1); tick(20);
    n_checks += 2;
    if (pulses != p0 + 1) begin n_fail++; $display("FAIL after_reset_pulse: %0d pulses required 1", pulses - p0); end
    if (rx_parallel !== 8'hA5) begin n_fail++; $display("FAIL after_reset_data: got %h required a5", rx_parallel); end
  endtask
  task automatic test_gating;
    int p0 = pulses;
    rx = 1'b0; tick(CPB);
    rx = 1'b0; tick(2 * CPB);
    tick(3); psel2 = 1'b0; tick(CPB - 3);
    tick(5 * CPB); rx = 1'b1; tick(30);
    psel2 = 1'b1; tick(30);
    n_checks += 2;
    if (pulses != p0) begin n_fail++; $display("FAIL gated_pulse: %0d pulses required 0", pulses - p0); end
    if (rx_parallel !== 8'hA5) begin n_fail++; $display("FAIL gated_data: got %h required a5", rx_parallel); end
  endtask
  task automatic test_back_to_back;
    int p0 = pulses;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick(20);
    n_checks += 3;
    if (pulses != p0 + 2) begin n_fail++; $display("FAIL b2b_pulses: %0d pulses required 2", pulses - p0); end
    if (rx_parallel !== 8'hC3) begin n_fail++; $display("FAIL b2b_data: got %h required c3", rx_parallel); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d frames outstanding required 0", exp_q.size()); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tick(1);
    test_reset;
    test_framing_error;
    test_glitch;
    test_valid_frame;
    test_reset_mid_frame;
    test_gating;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- APB-slave-side UART receive block: deserialises an 8N1 frame on rx_serial into a byte and reports completion on rx_done.
- Exposes the received byte on rx_parallel with a PREADY completion handshake.
- Sits as peripheral slot 2 (PSEL2) on the team's APB bus, alongside the UART transmitter and GPIO slaves.
- Bit timing is derived from PCLK by a clocks-per-bit parameter; there is no separate baud clock.

Parameters:
- CPB, 10, PCLK cycles per UART bit; must be >= 4. Mid-bit offset is CPB/2, integer floor.

Ports:
- PCLK  input  1  system clock; all logic on the rising edge.
- PRESET  input  1  synchronous, active-high reset.
- PENABLE  input  1  APB enable phase.
- PSEL2  input  1  APB select for this slave.
- PADDR  input  8  APB address; no decode in this block (reserved, ignored).
- PWRITE  input  1  APB direction; 0 = read. Receive runs only on reads.
- rx_serial  input  1  asynchronous serial line; idles high.
- PREADY  output  1  one-cycle pulse, coincident with rx_done, signalling the read data is valid.
- rx_done  output  1  one-cycle pulse when a valid frame has been captured.
- rx_parallel  output  8  last valid received byte.

Behaviour:
- Clock and reset:
  - Single clock, PCLK.
  - PRESET is synchronous and active-high.
  - Reset takes priority over everything, including mid-frame. It forces state IDLE, counters 0, PREADY=0, rx_done=0, rx_parallel=8'h00 and the synchroniser flops to 1.
- Input synchroniser: rx_serial passes through a 2-flop synchroniser to give rx_s. All sampling uses rx_s, which is rx_serial delayed 2 cycles.
- Enable: en = PSEL2 & PENABLE & ~PWRITE.
  - If en is 0 in any state other than IDLE, the FSM returns to IDLE on the next cycle.
  - An aborted frame leaves rx_parallel unchanged and produces no pulse.
- FSM states:
  - IDLE: counter clear. If en and rx_s==0, go to START.
  - START: count clocks. At count CPB/2-1, sample rx_s.
    - If the sample is 0, the start bit is confirmed: clear counter and bit index, go to DATA.
    - If the sample is 1, it was a glitch: go to IDLE.
  - DATA: count 0..CPB-1. At CPB-1, shift rx_s into shift[bit_idx] (LSB first).
    - If bit_idx==7, go to STOP; otherwise bit_idx+1.
    - Samples fall at mid-bit, because START ended at mid start bit.
  - STOP: at count CPB-1, sample rx_s.
    - If 1: load rx_parallel<=shift and go to DONE.
    - If 0 (framing error): discard the byte and go to IDLE. No pulse, rx_parallel unchanged.
  - DONE: for exactly one cycle, rx_done=1 and PREADY=1, then go to IDLE.
- Latency: a line stable high in IDLE never leaves IDLE.
- Back-to-back frames: the FSM is back in IDLE after DONE, which is about half a bit before the stop bit ends. The next start edge is detected normally.
- Outputs are registered. PREADY=0 and rx_done=0 in all states except DONE.
- rx_parallel holds its value indefinitely between valid frames.

Decomposition:
- Shared package (uart_pkg): the state enum {IDLE, START, DATA, STOP, DONE} and the frame constant DATA_BITS=8.
- This block uses the package; the UART transmitter is expected to reuse it as well.
- One natural sub-module: sync2, a 2-flop synchroniser with a reset value parameter. Everything else stays in one module.

Test Plan:
- Conditions for all scenarios: CPB=10, PCLK period 10, bit period 100, PSEL2=1, PENABLE=1, PWRITE=0, PRESET=0.
- Valid frame: start 0, data bits LSB-first 0,0,1,1,0,1,1,0, stop 1 -> rx_parallel=8'h6C. rx_done and PREADY are high for exactly 1 cycle, about 2+5+80+10 cycles after the start edge.
- Framing error: same bits but the stop bit is 0 -> no rx_done/PREADY pulse, rx_parallel keeps its previous value (8'h00 after reset), FSM returns to IDLE.
- Glitch start: rx low for 3 cycles then high -> FSM returns to IDLE, no pulse, rx_parallel unchanged.
- Reset mid-frame: assert PRESET for 1 cycle during bit 4 -> all outputs 0, and the following full frame 8'hA5 is received correctly.
- Gating and back-to-back:
  - Drop PSEL2 during a data bit -> frame aborted, no pulse.
  - Two consecutive frames 8'h3C then 8'hC3 with enable held -> two rx_done pulses, rx_parallel 8'h3C then 8'hC3.
